// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg
//   Shared definitions for the EX/MEM pipeline register:
//   - default GPR data and address widths
//   - memory-op code width and codes (0 means "no memory access")
//   - state encoding of the two-entry skid buffer
//   No ports; imported by ex_mem_reg and ex_mem_slot.
package ex_mem_reg_pkg;

  localparam int DATA_WIDTH_GPR = 32;
  localparam int GPR_ADDR_W     = 5;
  localparam int MEM_OP_W       = 4;

  localparam logic [MEM_OP_W-1:0] MOP_NONE = 4'd0;
  localparam logic [MEM_OP_W-1:0] MOP_LW   = 4'd3;
  localparam logic [MEM_OP_W-1:0] MOP_SW   = 4'd8;

  // EMPTY: nothing held, ONE: output register holds a beat,
  // TWO: output and skid registers both hold a beat
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ex_mem_state_e;

endpackage

// File: rtl/ex_mem_slot.sv
// ex_mem_slot
//   One valid bit plus one EX/MEM payload register.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset (clears everything)
//     clr         : flush; clears valid, rd_we and mem_op, data fields hold
//     load        : capture the *_in payload this cycle
//     valid_in    : next value of the valid bit (when not cleared)
//     *_in        : payload to capture
//     valid, *_o  : registered valid and payload
module ex_mem_slot
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_WIDTH_GPR,
  parameter int RADDR_W = GPR_ADDR_W,
  parameter int MOP_W   = MEM_OP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  alu_in,
  input  logic [RADDR_W-1:0] rd_addr_in,
  input  logic               rd_we_in,
  input  logic [MOP_W-1:0]   mem_op_in,
  input  logic [DATA_W-1:0]  store_data_in,
  output logic               valid,
  output logic [DATA_W-1:0]  alu_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic               rd_we_o,
  output logic [MOP_W-1:0]   mem_op_o,
  output logic [DATA_W-1:0]  store_data_o
);

  logic               valid_d, valid_q;
  logic [DATA_W-1:0]  alu_d, alu_q;
  logic [RADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic               rd_we_d, rd_we_q;
  logic [MOP_W-1:0]   mem_op_d, mem_op_q;
  logic [DATA_W-1:0]  store_data_d, store_data_q;

  // A cleared slot must never look like a pending write or memory access,
  // so only the control fields are zeroed; the data fields are don't-care.
  always_comb begin
    valid_d      = valid_q;
    alu_d        = alu_q;
    rd_addr_d    = rd_addr_q;
    rd_we_d      = rd_we_q;
    mem_op_d     = mem_op_q;
    store_data_d = store_data_q;
    if (clr) begin
      valid_d  = 1'b0;
      rd_we_d  = 1'b0;
      mem_op_d = MOP_W'(MOP_NONE);
    end else begin
      valid_d = valid_in;
      if (load) begin
        alu_d        = alu_in;
        rd_addr_d    = rd_addr_in;
        rd_we_d      = rd_we_in;
        mem_op_d     = mem_op_in;
        store_data_d = store_data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      alu_q        <= '0;
      rd_addr_q    <= '0;
      rd_we_q      <= 1'b0;
      mem_op_q     <= '0;
      store_data_q <= '0;
    end else begin
      valid_q      <= valid_d;
      alu_q        <= alu_d;
      rd_addr_q    <= rd_addr_d;
      rd_we_q      <= rd_we_d;
      mem_op_q     <= mem_op_d;
      store_data_q <= store_data_d;
    end
  end

  assign valid        = valid_q;
  assign alu_o        = alu_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_we_o      = rd_we_q;
  assign mem_op_o     = mem_op_q;
  assign store_data_o = store_data_q;

endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg
//   EX/MEM pipeline register built as a two-entry skid buffer (OUT + SKID)
//   so that ex_ready is a flop and never depends combinationally on mem_ready.
//   Ports:
//     clk, rst_n           : clock, synchronous active-low reset
//     flush                : discard everything held and the incoming beat
//     ex_valid / ex_ready  : upstream handshake (ex_ready registered)
//     alu_out, ex_rd_addr, ex_rd_we, ex_mem_op, ex_store_data : EX payload
//     mem_valid / mem_ready: downstream handshake
//     mem_*                : registered payload from the OUT register
//     fwd_*                : forwarding of OUT's ALU result (only with
//                            macro EX_MEM_FWD_EN defined)
//   Optional feature macro: EX_MEM_FWD_EN
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_WIDTH_GPR,
  parameter int RADDR_W = GPR_ADDR_W,
  parameter int MOP_W   = MEM_OP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic [RADDR_W-1:0] ex_rd_addr,
  input  logic               ex_rd_we,
  input  logic [MOP_W-1:0]   ex_mem_op,
  input  logic [DATA_W-1:0]  ex_store_data,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [DATA_W-1:0]  mem_alu_out,
  output logic [RADDR_W-1:0] mem_rd_addr,
  output logic               mem_rd_we,
  output logic [MOP_W-1:0]   mem_mem_op,
  output logic [DATA_W-1:0]  mem_store_data
`ifdef EX_MEM_FWD_EN
  ,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd_addr,
  output logic [DATA_W-1:0]  fwd_data
`endif
);

  ex_mem_state_e state_d, state_q;
  logic          ex_ready_d, ex_ready_q;

  logic accept, drain, in_we;
  logic out_load, skid_load;
  logic out_valid, skid_valid;

  logic [DATA_W-1:0]  skid_alu, skid_store_data;
  logic [RADDR_W-1:0] skid_rd_addr;
  logic               skid_rd_we;
  logic [MOP_W-1:0]   skid_mem_op;

  logic [DATA_W-1:0]  out_alu_in, out_store_data_in;
  logic [RADDR_W-1:0] out_rd_addr_in;
  logic               out_rd_we_in;
  logic [MOP_W-1:0]   out_mem_op_in;

  assign accept = ex_valid & ex_ready_q;
  assign drain  = out_valid & mem_ready;

  // x0 is hardwired to zero, so a write to it is dropped at capture time
  assign in_we = ex_rd_we & (ex_rd_addr != '0);

  // Next state and register load enables. Flush overrides everything and
  // also drops a beat presented in the same cycle.
  always_comb begin
    state_d   = state_q;
    out_load  = 1'b0;
    skid_load = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d  = ST_ONE;
          out_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !drain) begin
          state_d   = ST_TWO;
          skid_load = 1'b1;
        end else if (drain && !accept) begin
          state_d = ST_EMPTY;
        end else if (accept && drain) begin
          out_load = 1'b1;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d  = ST_ONE;
          out_load = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d   = ST_EMPTY;
      out_load  = 1'b0;
      skid_load = 1'b0;
    end
    ex_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      ex_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ex_ready_q <= ex_ready_d;
    end
  end

  // OUT refills from SKID whenever SKID is occupied, which keeps beats in
  // arrival order; otherwise it takes the beat straight from EX.
  always_comb begin
    out_alu_in        = alu_out;
    out_rd_addr_in    = ex_rd_addr;
    out_rd_we_in      = in_we;
    out_mem_op_in     = ex_mem_op;
    out_store_data_in = ex_store_data;
    if (skid_valid) begin
      out_alu_in        = skid_alu;
      out_rd_addr_in    = skid_rd_addr;
      out_rd_we_in      = skid_rd_we;
      out_mem_op_in     = skid_mem_op;
      out_store_data_in = skid_store_data;
    end
  end

  ex_mem_slot #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .MOP_W(MOP_W)) u_out (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (flush),
    .load         (out_load),
    .valid_in     (state_d != ST_EMPTY),
    .alu_in       (out_alu_in),
    .rd_addr_in   (out_rd_addr_in),
    .rd_we_in     (out_rd_we_in),
    .mem_op_in    (out_mem_op_in),
    .store_data_in(out_store_data_in),
    .valid        (out_valid),
    .alu_o        (mem_alu_out),
    .rd_addr_o    (mem_rd_addr),
    .rd_we_o      (mem_rd_we),
    .mem_op_o     (mem_mem_op),
    .store_data_o (mem_store_data)
  );

  ex_mem_slot #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .MOP_W(MOP_W)) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (flush),
    .load         (skid_load),
    .valid_in     (state_d == ST_TWO),
    .alu_in       (alu_out),
    .rd_addr_in   (ex_rd_addr),
    .rd_we_in     (in_we),
    .mem_op_in    (ex_mem_op),
    .store_data_in(ex_store_data),
    .valid        (skid_valid),
    .alu_o        (skid_alu),
    .rd_addr_o    (skid_rd_addr),
    .rd_we_o      (skid_rd_we),
    .mem_op_o     (skid_mem_op),
    .store_data_o (skid_store_data)
  );

  // out_valid tracks state_q != ST_EMPTY exactly
  assign mem_valid = out_valid;
  assign ex_ready  = ex_ready_q;

`ifdef EX_MEM_FWD_EN
  // Only a non-memory result is final in MEM; loads are not yet available
  assign fwd_valid   = mem_valid & mem_rd_we & (mem_mem_op == MOP_W'(MOP_NONE));
  assign fwd_rd_addr = mem_rd_addr;
  assign fwd_data    = mem_alu_out;
`endif

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32 (DATA_WIDTH_GPR), width of ALU result and store data.
REQ-002 SHALL have parameter RADDR_W, default 5, width of GPR address.
REQ-003 SHALL have parameter MOP_W, default 4, width of memory-op code.
REQ-004 SHALL have ports, one per line:
 clk  in  1  clock; all state updates on its rising edge
 rst_n  in  1  reset, synchronous, active-low
 flush  in  1  synchronous pipeline flush
 ex_valid  in  1  EX beat valid
 ex_ready  out  1  stage can accept a beat
 alu_out  in  DATA_W  ALU result
 ex_rd_addr  in  RADDR_W  destination GPR
 ex_rd_we  in  1  GPR write request
 ex_mem_op  in  MOP_W  load/store op, 0 = none
 ex_store_data  in  DATA_W  store data
 mem_valid  out  1  MEM beat valid
 mem_ready  in  1  MEM accepts beat
 mem_alu_out  out  DATA_W  registered ALU result
 mem_rd_addr  out  RADDR_W  registered destination
 mem_rd_we  out  1  registered write enable
 mem_mem_op  out  MOP_W  registered memory op
 mem_store_data  out  DATA_W  registered store data
 fwd_valid  out  1  forwarding data valid (EX_MEM_FWD_EN only)
 fwd_rd_addr  out  RADDR_W  forwarding destination (EX_MEM_FWD_EN only)
 fwd_data  out  DATA_W  forwarding value (EX_MEM_FWD_EN only)
REQ-005 One clock; reset is synchronous and active-low, ports clk and rst_n.

Function
REQ-006 Block SHALL be a 2-entry skid buffer: output register (OUT) plus skid register (SKID).
REQ-007 States SHALL be EMPTY (none valid), ONE (OUT valid), TWO (OUT and SKID valid).
REQ-008 Accept = ex_valid & ex_ready; drain = mem_valid & mem_ready.
REQ-009 ex_ready SHALL be registered and equal to (state != TWO); no combinational path from mem_ready.
REQ-010 Transitions: EMPTY-accept->ONE; ONE-accept&!drain->TWO; ONE-drain&!accept->EMPTY; ONE-accept&drain->ONE (new beat to OUT); TWO-drain->ONE (SKID to OUT); otherwise hold.
REQ-011 Latency SHALL be exactly 1 cycle from accept to mem_valid when OUT is free or draining.
REQ-012 Beat order SHALL be preserved; no beat duplicated or dropped except by flush.
REQ-013 mem_valid SHALL equal (state != EMPTY); mem_* outputs SHALL hold stable while mem_valid & !mem_ready.
REQ-014 Captured rd_we SHALL be forced 0 when ex_rd_addr == 0.
REQ-015 flush SHALL take priority over all other events: next state EMPTY, incoming beat in flush cycle discarded, ex_ready = 1 next cycle.
REQ-016 Data registers need not clear on flush; only valid state and rd_we/mem_op SHALL clear to 0.

Reset
REQ-017 On rst_n = 0 at a clk edge: state EMPTY, ex_ready = 1, mem_valid = 0, all mem_* and fwd_* outputs = 0.
REQ-018 Reset mid-operation SHALL discard OUT and SKID contents identically to flush.

Configuration
REQ-019 Macro EX_MEM_FWD_EN defined: fwd_valid = mem_valid & mem_rd_we & (mem_mem_op == 0); fwd_rd_addr = mem_rd_addr; fwd_data = mem_alu_out (combinational from OUT).
REQ-020 Macro EX_MEM_FWD_EN undefined: fwd_* ports SHALL not exist; no forwarding logic synthesised.

Structure
REQ-021 DATA_WIDTH_GPR, GPR address width, MEM_OP codes and state encodings SHALL live in the shared define.v package.
REQ-022 One sub-module natural: ex_mem_slot (single valid+payload register), instantiated for OUT and SKID.

Verification
REQ-023 Single beat: alu_out=55, rd=3, we=1, mem_ready=1 -> next cycle mem_valid=1, mem_alu_out=55, mem_rd_we=1; following cycle mem_valid=0.
REQ-024 Backpressure: mem_ready=0, send beats 11,22 -> ex_ready=0 after 2nd; raise mem_ready -> 11 then 22 on consecutive cycles, ex_ready=1 after 22 accepted.
REQ-025 x0 write: rd=0, we=1, alu_out=7 -> mem_rd_we=0, mem_alu_out=7.
REQ-026 Flush in TWO with ex_valid=1 -> next cycle mem_valid=0, ex_ready=1; no flushed beat ever appears.
REQ-027 Reset mid-stream (state TWO, rst_n=0 one cycle) -> all outputs 0, ex_ready=1.
REQ-028 EX_MEM_FWD_EN: beat alu_out=33, rd=5, we=1, mem_op=0 -> fwd_valid=1, fwd_rd_addr=5, fwd_data=33; same with mem_op=load -> fwd_valid=0.
